// File: rtl/rx_flow_pkg.sv
// Shared types and default thresholds for the ADC-to-demod flow controller.
package rx_flow_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        THROTTLE = 2'd2,
        DISCARD  = 2'd3
    } flow_state_t;

    localparam int DEF_ADC_DATA_WIDTH = 12;
    localparam int DEF_ADC_CNT_SIZE   = 10;
    localparam int DEF_I2C_CNT_SIZE   = 8;
    localparam int DEF_I2C_HI         = 96;
    localparam int DEF_I2C_LO         = 32;
    localparam int DEF_ADC_HI         = 480;
    localparam int DEF_ADC_LO         = 256;
    localparam int DEF_IRQ_LEVEL      = 16;
    localparam int DROP_W             = 16;

endpackage

// File: rtl/rx_flow_ctrl_if.sv
// Valid/ready sample stream between ADC FIFO, flow controller and demod.
interface rx_flow_ctrl_if
    import rx_flow_pkg::*;
#(
    parameter int W = DEF_ADC_DATA_WIDTH
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rx_flow_ctrl_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/rx_flow_ctrl.sv
// ADC FIFO -> BFSK demod flow controller with throttle, discard and irq.
// Define RX_FLOW_STATS_EN to build the forwarded-sample counter fwd_cnt.
module rx_flow_ctrl
    import rx_flow_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = DEF_ADC_DATA_WIDTH,
    parameter int ADC_CNT_SIZE   = DEF_ADC_CNT_SIZE,
    parameter int I2C_CNT_SIZE   = DEF_I2C_CNT_SIZE,
    parameter int I2C_HI         = DEF_I2C_HI,
    parameter int I2C_LO         = DEF_I2C_LO,
    parameter int ADC_HI         = DEF_ADC_HI,
    parameter int ADC_LO         = DEF_ADC_LO,
    parameter int IRQ_LEVEL      = DEF_IRQ_LEVEL,
    parameter int DROP_W         = rx_flow_pkg::DROP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [ADC_CNT_SIZE-1:0] adc_cnt,
    input  logic [I2C_CNT_SIZE-1:0] i2c_cnt,
    rx_flow_ctrl_if.slave           s,
    rx_flow_ctrl_if.master          m,
    input  logic                    drop_clr,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    overrun,
    output logic                    irq,
    output logic [1:0]              state,
    output logic [31:0]             fwd_cnt
);

    if ((I2C_LO >= I2C_HI) || (ADC_LO >= ADC_HI) ||
        (ADC_HI >= (1 << (ADC_CNT_SIZE - 1)) + 1)) begin : g_param_chk
        $error("rx_flow_ctrl: inconsistent threshold parameters");
    end

    localparam logic [I2C_CNT_SIZE-1:0] I2C_HI_V = I2C_CNT_SIZE'(I2C_HI);
    localparam logic [I2C_CNT_SIZE-1:0] I2C_LO_V = I2C_CNT_SIZE'(I2C_LO);
    localparam logic [I2C_CNT_SIZE-1:0] IRQ_V    = I2C_CNT_SIZE'(IRQ_LEVEL);
    localparam logic [ADC_CNT_SIZE-1:0] ADC_HI_V = ADC_CNT_SIZE'(ADC_HI);
    localparam logic [ADC_CNT_SIZE-1:0] ADC_LO_V = ADC_CNT_SIZE'(ADC_LO);

    flow_state_t               cur_q;
    flow_state_t               nxt;
    logic                      hold;
    logic                      drop;
    logic                      s_rdy;
    logic                      m_vld;
    logic [ADC_DATA_WIDTH-1:0] sample;

    assign sample  = s.data;
    assign m.data  = sample;
    assign m.valid = m_vld;
    assign s.ready = s_rdy;
    assign state   = cur_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= IDLE;
        end else begin
            cur_q <= nxt;
        end
    end

    // An offered sample must complete before RUN can be left.
    always_comb begin
        s_rdy = 1'b0;
        m_vld = 1'b0;
        drop  = 1'b0;
        nxt   = cur_q;
        unique case (cur_q)
            IDLE:     ;
            RUN: begin
                m_vld = s.valid;
                s_rdy = m.ready;
            end
            THROTTLE: ;
            DISCARD: begin
                s_rdy = 1'b1;
                drop  = s.valid;
            end
        endcase
        hold = m_vld && !m.ready;
        if (!hold) begin
            if (!enable) begin
                nxt = IDLE;
            end else begin
                unique case (cur_q)
                    IDLE: nxt = RUN;
                    RUN: begin
                        if (i2c_cnt >= I2C_HI_V) nxt = THROTTLE;
                    end
                    THROTTLE: begin
                        if (i2c_cnt <= I2C_LO_V)      nxt = RUN;
                        else if (adc_cnt >= ADC_HI_V) nxt = DISCARD;
                    end
                    DISCARD: begin
                        if (i2c_cnt <= I2C_LO_V)      nxt = RUN;
                        else if (adc_cnt <= ADC_LO_V) nxt = THROTTLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop),
        .clr (drop_clr),
        .q   (drop_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (drop)          overrun <= 1'b1;
            else if (drop_clr) overrun <= 1'b0;
            irq <= (i2c_cnt >= IRQ_V) | overrun;
        end
    end

`ifdef RX_FLOW_STATS_EN
    logic [31:0] fwd_q;
    logic        xfer;

    assign xfer    = m_vld && m.ready;
    assign fwd_cnt = fwd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q <= '0;
        end else if (xfer) begin
            fwd_q <= fwd_q + 32'd1;
        end
    end
`else
    assign fwd_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_flow_ctrl.sv
// Self-checking bench for rx_flow_ctrl: vector table, scoreboard, corner cases.
`timescale 1ns/1ps
module tb_rx_flow_ctrl;
    import rx_flow_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        drop_clr;
    logic [9:0]  adc_cnt;
    logic [7:0]  i2c_cnt;
    logic [15:0] drop_cnt;
    logic        overrun;
    logic        irq;
    logic [1:0]  state;
    logic [31:0] fwd_cnt;

    rx_flow_ctrl_if #(.W(12)) s_if ();
    rx_flow_ctrl_if #(.W(12)) m_if ();

    rx_flow_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .adc_cnt  (adc_cnt),
        .i2c_cnt  (i2c_cnt),
        .s        (s_if),
        .m        (m_if),
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt),
        .overrun  (overrun),
        .irq      (irq),
        .state    (state),
        .fwd_cnt  (fwd_cnt)
    );

    typedef struct {
        logic        en;
        logic [9:0]  adc;
        logic [7:0]  i2c;
        logic        sv;
        logic [11:0] data;
        logic        mr;
        logic        sr;
        logic        mv;
        logic        xfer;
        logic [1:0]  st;
        logic        irq;
    } vec_t;

    vec_t        tbl[20];
    logic [11:0] sbq[$];
    int          total = 0;
    int          bad = 0;
    int          exp_fwd = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        sbq.push_back(d);
        exp_fwd++;
    endtask

    always @(negedge clk) begin
        if (!rst && m_if.valid && m_if.ready) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %0h want none", m_if.data);
            end else begin
                logic [11:0] e;
                e = sbq.pop_front();
                if (m_if.data !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %0h want %0h", m_if.data, e);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 10'd0,   8'd0,   1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tbl[1]  = '{1'b1, 10'd0,   8'd0,   1'b1, 12'h5A5, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[2]  = '{1'b1, 10'd0,   8'd50,  1'b1, 12'h123, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[3]  = '{1'b1, 10'd0,   8'd95,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[4]  = '{1'b1, 10'd0,   8'd96,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[5]  = '{1'b1, 10'd100, 8'd60,  1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[6]  = '{1'b1, 10'd100, 8'd33,  1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[7]  = '{1'b1, 10'd100, 8'd32,  1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 10'd0,   8'd0,   1'b1, 12'h0F0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[9]  = '{1'b1, 10'd0,   8'd0,   1'b1, 12'h0F0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{1'b1, 10'd0,   8'd120, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[11] = '{1'b1, 10'd479, 8'd120, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[12] = '{1'b1, 10'd480, 8'd120, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[13] = '{1'b1, 10'd300, 8'd120, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[14] = '{1'b1, 10'd256, 8'd120, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[15] = '{1'b1, 10'd500, 8'd100, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        tbl[16] = '{1'b1, 10'd500, 8'd32,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        tbl[17] = '{1'b0, 10'd0,   8'd0,   1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 10'd0,   8'd0,   1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[19] = '{1'b1, 10'd0,   8'd0,   1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};

        rst = 1'b1;
        enable = 1'b1;
        drop_clr = 1'b0;
        adc_cnt = '0;
        i2c_cnt = '0;
        s_if.valid = 1'b0;
        s_if.data = '0;
        m_if.ready = 1'b0;
        step();
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_fwd", 32'(fwd_cnt), 32'd0);
        chk("rst_srdy", 32'(s_if.ready), 32'd0);
        chk("rst_mvld", 32'(m_if.valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            enable = tbl[i].en;
            adc_cnt = tbl[i].adc;
            i2c_cnt = tbl[i].i2c;
            s_if.valid = tbl[i].sv;
            s_if.data = tbl[i].data;
            m_if.ready = tbl[i].mr;
            #1;
            chk($sformatf("v%0d_srdy", i), 32'(s_if.ready), 32'(tbl[i].sr));
            chk($sformatf("v%0d_mvld", i), 32'(m_if.valid), 32'(tbl[i].mv));
            if (tbl[i].xfer) push(tbl[i].data);
            step();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
        end
        chk("tbl_drop", 32'(drop_cnt), 32'd0);

        // Throttle then discard with counted drops.
        s_if.valid = 1'b0;
        i2c_cnt = 8'd100;
        step();
        chk("a_thr", 32'(state), 32'(THROTTLE));
        adc_cnt = 10'd480;
        s_if.valid = 1'b1;
        s_if.data = 12'h111;
        #1;
        chk("a_thr_srdy", 32'(s_if.ready), 32'd0);
        step();
        chk("a_dis", 32'(state), 32'(DISCARD));
        chk("a_drop0", 32'(drop_cnt), 32'd0);
        chk("a_dis_srdy", 32'(s_if.ready), 32'd1);
        chk("a_dis_mvld", 32'(m_if.valid), 32'd0);
        repeat (10) step();
        chk("a_drop10", 32'(drop_cnt), 32'd10);
        chk("a_ovr", 32'(overrun), 32'd1);
        chk("a_dis2", 32'(state), 32'(DISCARD));

        s_if.valid = 1'b0;
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("a_clr_drop", 32'(drop_cnt), 32'd0);
        chk("a_clr_ovr", 32'(overrun), 32'd0);
        s_if.valid = 1'b1;
        repeat (7) step();
        chk("a_drop7", 32'(drop_cnt), 32'd7);
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("a_clrinc_drop", 32'(drop_cnt), 32'd1);
        chk("a_clrinc_ovr", 32'(overrun), 32'd1);
        repeat (65540) step();
        chk("a_sat", 32'(drop_cnt), 32'h0000FFFF);

        s_if.valid = 1'b0;
        adc_cnt = 10'd256;
        step();
        chk("a_back_thr", 32'(state), 32'(THROTTLE));
        adc_cnt = 10'd480;
        step();
        chk("a_re_dis", 32'(state), 32'(DISCARD));
        enable = 1'b0;
        i2c_cnt = 8'd0;
        step();
        chk("a_dis_idle", 32'(state), 32'(IDLE));
        chk("a_irq_ovr", 32'(irq), 32'd1);
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("a_ovr_clr", 32'(overrun), 32'd0);
        chk("a_irq_lag", 32'(irq), 32'd1);
        step();
        chk("a_irq_off", 32'(irq), 32'd0);
        i2c_cnt = 8'd16;
        step();
        chk("a_irq16", 32'(irq), 32'd1);
        i2c_cnt = 8'd15;
        step();
        chk("a_irq15", 32'(irq), 32'd0);

        // Hold-off: pending sample blocks leaving RUN.
        enable = 1'b1;
        i2c_cnt = 8'd0;
        step();
        chk("b_run", 32'(state), 32'(RUN));
        s_if.valid = 1'b1;
        s_if.data = 12'h3C3;
        m_if.ready = 1'b0;
        i2c_cnt = 8'd100;
        #1;
        chk("b_mvld", 32'(m_if.valid), 32'd1);
        chk("b_srdy", 32'(s_if.ready), 32'd0);
        step();
        chk("b_hold1", 32'(state), 32'(RUN));
        step();
        chk("b_hold2", 32'(state), 32'(RUN));
        chk("b_mvld2", 32'(m_if.valid), 32'd1);
        m_if.ready = 1'b1;
        push(12'h3C3);
        step();
        chk("b_thr", 32'(state), 32'(THROTTLE));
        s_if.valid = 1'b0;
        i2c_cnt = 8'd0;
        step();
        chk("b_run2", 32'(state), 32'(RUN));
        s_if.valid = 1'b1;
        s_if.data = 12'h0AB;
        m_if.ready = 1'b0;
        enable = 1'b0;
        step();
        chk("b_en_hold", 32'(state), 32'(RUN));
        m_if.ready = 1'b1;
        push(12'h0AB);
        step();
        chk("b_idle", 32'(state), 32'(IDLE));
        s_if.valid = 1'b0;

        // Reset in the middle of an offered transfer.
        enable = 1'b1;
        i2c_cnt = 8'd50;
        step();
        chk("c_run", 32'(state), 32'(RUN));
        s_if.valid = 1'b1;
        s_if.data = 12'h2AA;
        rst = 1'b1;
        #1;
        exp_fwd = 0;
        chk("c_state", 32'(state), 32'(IDLE));
        chk("c_srdy", 32'(s_if.ready), 32'd0);
        chk("c_mvld", 32'(m_if.valid), 32'd0);
        chk("c_irq", 32'(irq), 32'd0);
        chk("c_fwd", 32'(fwd_cnt), 32'd0);
        step();
        rst = 1'b0;
        s_if.valid = 1'b0;
        i2c_cnt = 8'd0;
        step();
        chk("c_run2", 32'(state), 32'(RUN));

        for (int k = 0; k < 5; k++) begin
            s_if.valid = 1'b1;
            s_if.data = 12'h100 + 12'(k * 17);
            m_if.ready = 1'b1;
            push(s_if.data);
            step();
        end
        s_if.valid = 1'b0;
        step();
`ifdef RX_FLOW_STATS_EN
        chk("d_fwd", fwd_cnt, 32'(exp_fwd));
`else
        chk("d_fwd", fwd_cnt, 32'd0);
`endif
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
